// File: rtl/dsc_mul_nway.sv
// dsc_mul_nway: deterministic stochastic-computing multiplier for NUM_INPUTS
// unsigned SNG_WIDTH-bit operands. Nested single-clock counters drive the
// unary stream generators, and the AND of all streams is accumulated over the
// full period into the exact binary product.
//
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   start  request a multiplication (sampled only in IDLE)
//   ops    packed operands, operand i = ops[i*SNG_WIDTH +: SNG_WIDTH]
//   busy   high while streams are being generated/accumulated
//   done   one-cycle pulse when z holds the final product
//   z      product accumulator, held until the next accepted start
//
// Optional feature macro: DSC_MUL_EARLY_TERM_EN
//   When defined, RUN stops once the top counter reaches the top operand,
//   and a zero operand skips RUN entirely (IDLE -> DONE).
module dsc_mul_nway #(
  parameter int unsigned SNG_WIDTH  = 6,
  parameter int unsigned NUM_INPUTS = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0]  ops,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_INPUTS*SNG_WIDTH-1:0]  z
);

  localparam int unsigned W  = SNG_WIDTH;
  localparam int unsigned N  = NUM_INPUTS;
  localparam int unsigned ZW = N * W;
  localparam logic [W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [N-1:0][W-1:0]    ops_q, ops_d;
  logic [N-1:0][W-1:0]    cnt_q, cnt_d;
  logic [ZW-1:0]          z_q, z_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [N-1:0]           inc_en;
  logic [N-1:0]           stream;
  logic [N-1:0][W-1:0]    cnt_inc;
  logic                   all_max;
  logic                   prod_bit;
  logic                   last_run;

  // Enable chain: counter i steps only when every lower counter is at max.
  always_comb begin
    inc_en  = '0;
    stream  = '0;
    cnt_inc = cnt_q;
    all_max = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      inc_en[i]  = all_max;
      all_max    = all_max && (cnt_q[i] == CNT_MAX);
      stream[i]  = (cnt_q[i] < ops_q[i]);
      cnt_inc[i] = inc_en[i] ? (cnt_q[i] + W'(1)) : cnt_q[i];
    end
    prod_bit = &stream;
  end

`ifdef DSC_MUL_EARLY_TERM_EN
  logic any_zero_in;

  // Past cnt[N-1] == op[N-1]-1 every product bit is zero, so stop there.
  assign last_run = inc_en[N-1] && (cnt_q[N-1] == (ops_q[N-1] - W'(1)));

  always_comb begin
    any_zero_in = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (ops[i*W +: W] == '0) any_zero_in = 1'b1;
    end
  end
`else
  assign last_run = all_max;
`endif

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ops_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ops_q   <= ops_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ops_d   = ops_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ops_d   = ops;
          cnt_d   = '0;
          z_d     = '0;
`ifdef DSC_MUL_EARLY_TERM_EN
          if (any_zero_in) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
`else
          state_d = ST_RUN;
          busy_d  = 1'b1;
`endif
        end
      end
      ST_RUN: begin
        z_d   = z_q + ZW'(prod_bit);
        cnt_d = cnt_inc;
        if (last_run) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        // Entering from RUN already raised done; the skip path raises it here.
        if (!done_q) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign z    = z_q;

endmodule

// File: tb/tb_dsc_mul_nway.sv
// Self-checking bench for dsc_mul_nway: a W=3,N=2 and a W=3,N=3 instance,
// table vectors, random operands against a product/latency model, and
// hand-written sequences for hold, mid-run start, retrigger and async reset.
module tb_dsc_mul_nway;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [5:0] ops_a = '0;
  logic [8:0] ops_b = '0;
  logic       busy_a, done_a, busy_b, done_b;
  logic [5:0] z_a;
  logic [8:0] z_b;

  int n_checks = 0;
  int n_pass   = 0;
  int sel_n    = 2;

  logic       busy_s, done_s;
  logic [8:0] z_s;

`ifdef DSC_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  always #5 clk = ~clk;

  dsc_mul_nway #(.SNG_WIDTH(3), .NUM_INPUTS(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .ops(ops_a),
    .busy(busy_a), .done(done_a), .z(z_a)
  );

  dsc_mul_nway #(.SNG_WIDTH(3), .NUM_INPUTS(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .ops(ops_b),
    .busy(busy_b), .done(done_b), .z(z_b)
  );

  always_comb begin
    if (sel_n == 3) begin
      busy_s = busy_b;
      done_s = done_b;
      z_s    = z_b;
    end else begin
      busy_s = busy_a;
      done_s = done_a;
      z_s    = {3'b000, z_a};
    end
  end

  typedef struct {
    int n;
    int a;
    int b;
    int c;
    int z;
  } vec_t;

  // Reference model: product and busy length from the operand values alone.
  function automatic int model_prod(int n, int a, int b, int c);
    return (n == 3) ? a * b * c : a * b;
  endfunction

  function automatic bit model_zero(int n, int a, int b, int c);
    return (a == 0) || (b == 0) || (n == 3 && c == 0);
  endfunction

  function automatic int model_busy(int n, int a, int b, int c);
    int top;
    top = (n == 3) ? c : b;
    if (!EARLY) return 1 << (n * 3);
    if (model_zero(n, a, b, c)) return 0;
    return top * (1 << ((n - 1) * 3));
  endfunction

  function automatic int model_lat(int n, int a, int b, int c);
    if (EARLY && model_zero(n, a, b, c)) return 2;
    return model_busy(n, a, b, c) + 1;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply(input int n, input int a, input int b, input int c);
    sel_n = n;
    if (n == 3) begin
      ops_b   = {3'(c), 3'(b), 3'(a)};
      start_b = 1'b1;
    end else begin
      ops_a   = {3'(b), 3'(a)};
      start_a = 1'b1;
    end
  endtask

  // Waits for done after the accept edge; lat counts negedges since accept.
  task automatic wait_done(output int lat, output int bcnt, output bit seen);
    lat  = 1;
    bcnt = 0;
    seen = 1'b0;
    while (lat < 2000) begin
      if (done_s) begin
        seen = 1'b1;
        break;
      end
      if (busy_s) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_mul(input int n, input int a, input int b, input int c,
                         input int exp_z, input string tag);
    int lat, bcnt;
    bit seen;
    @(negedge clk);
    apply(n, a, b, c);
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    wait_done(lat, bcnt, seen);
    check({tag, " done_seen"}, int'(seen), 1);
    check({tag, " busy_cycles"}, bcnt, model_busy(n, a, b, c));
    check({tag, " done_latency"}, lat, model_lat(n, a, b, c));
    check({tag, " z"}, int'(z_s), exp_z);
    check({tag, " busy_at_done"}, int'(busy_s), 0);
    @(negedge clk);
    check({tag, " done_one_cycle"}, int'(done_s), 0);
    check({tag, " z_held"}, int'(z_s), exp_z);
  endtask

  initial begin
    vec_t tbl[8];
    int lat, bcnt, ra, rb, rc;
    bit seen;

    tbl[0] = '{2, 5, 6, 0, 30};
    tbl[1] = '{2, 7, 7, 0, 49};
    tbl[2] = '{2, 7, 2, 0, 14};
    tbl[3] = '{2, 0, 5, 0, 0};
    tbl[4] = '{2, 1, 1, 0, 1};
    tbl[5] = '{3, 0, 7, 7, 0};
    tbl[6] = '{3, 2, 3, 7, 42};
    tbl[7] = '{3, 7, 7, 7, 343};

    // Reset state.
    #12;
    check("rst busy_a", int'(busy_a), 0);
    check("rst done_a", int'(done_a), 0);
    check("rst z_a", int'(z_a), 0);
    check("rst busy_b", int'(busy_b), 0);
    check("rst z_b", int'(z_b), 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_mul(tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].z,
              $sformatf("vec%0d", i));
    end

    // z holds the last product through idle cycles.
    run_mul(2, 5, 6, 0, 30, "hold_run");
    for (int i = 0; i < 10; i++) check($sformatf("hold z%0d", i), int'(z_a), 30);

    // Random operands against the model.
    for (int i = 0; i < 10; i++) begin
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      run_mul(2, ra, rb, 0, model_prod(2, ra, rb, 0), $sformatf("rnd2_%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      ra = int'($urandom_range(0, 7));
      rb = int'($urandom_range(0, 7));
      rc = int'($urandom_range(0, 7));
      run_mul(3, ra, rb, rc, model_prod(3, ra, rb, rc), $sformatf("rnd3_%0d", i));
    end

    // Start and operand change mid-run are ignored.
    sel_n = 2;
    @(negedge clk);
    apply(2, 5, 6, 0);
    @(negedge clk);
    start_a = 1'b0;
    repeat (9) @(negedge clk);
    ops_a   = {3'd7, 3'd7};
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(lat, bcnt, seen);
    check("midrun done_seen", int'(seen), 1);
    check("midrun busy_cycles", bcnt + 10, model_busy(2, 5, 6, 0));
    check("midrun z", int'(z_a), 30);
    bcnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy_a || done_a) bcnt++;
    end
    check("midrun no_second_run", bcnt, 0);

    // Held start retriggers from IDLE on the cycle after DONE.
    @(negedge clk);
    apply(2, 1, 1, 0);
    @(negedge clk);
    wait_done(lat, bcnt, seen);
    check("retrig z", int'(z_a), 1);
    @(negedge clk);
    check("retrig idle_gap", int'(busy_a), 0);
    @(negedge clk);
    check("retrig busy_again", int'(busy_a), 1);
    start_a = 1'b0;
    wait_done(lat, bcnt, seen);
    check("retrig second_done", int'(seen), 1);
    @(negedge clk);

    // Asynchronous reset mid-run aborts immediately.
    @(negedge clk);
    apply(2, 5, 6, 0);
    @(negedge clk);
    start_a = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst busy", int'(busy_a), 0);
    check("arst done", int'(done_a), 0);
    check("arst z", int'(z_a), 0);
    @(negedge clk);
    rst = 1'b1;
    bcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy_a || done_a) bcnt++;
    end
    check("arst stays_idle", bcnt, 0);
    run_mul(2, 3, 3, 0, 9, "after_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
